pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised elastic pipeline register; successor to the fixed-field stage latches.
//  Carries one opaque DATA_W-bit payload, packed by the instantiating stage.
//  Uses valid/ready handshaking plus stall, flush and sticky-halt control.
//  Optional 2-entry skid buffer decouples upstream ready from downstream ready.
//  Used between IF/ID/EX/MEM/WB, one instance per boundary.
// PARAMETERS
//  DATA_W     128  payload width in bits (>=1)
//  SKID       1    0 = single-entry register; 1 = 2-entry skid buffer (full throughput, registered in_ready)
//  FLUSH_VAL  '0   value loaded into every data register on reset and on flush
// PORTS
//  CLK        in   1       clock, rising edge
//  nRST       in   1       asynchronous active-low reset
//  in_valid   in   1       upstream beat valid
//  in_ready   out  1       stage can accept a beat
//  in_data    in   DATA_W  upstream payload
//  in_halt    in   1       beat carries HALT
//  out_valid  out  1       head entry valid
//  out_ready  in   1       downstream accepts head
//  out_data   out  DATA_W  head payload
//  out_halt   out  1       head beat carries HALT (= out_valid & head halt bit)
//  stall      in   1       freeze stage: no push, no pop
//  flush      in   1       synchronous kill of all held and incoming beats
//  occupancy  out  2       entries held (0..2; max 1 when SKID=0)
//  halt_seen  out  1       sticky: a HALT beat has left the stage
// BEHAVIOUR
//  Reset (nRST=0, async):
//   - occupancy=0, out_valid=0, out_halt=0, halt_seen=0.
//   - Data registers = FLUSH_VAL; in_ready=1 after release.
//  push = in_valid & in_ready; pop = out_valid & out_ready & !stall.
//  Every output is registered except in_ready when SKID=0.
//  Latency: a pushed beat appears on out_* the next cycle; data/halt are never modified.
//  Priority per edge: flush > stall > push/pop.
//  flush=1: occupancy->0 and data->FLUSH_VAL at the next edge; in_ready=0 that cycle.
//   - Beats offered in the flush cycle are dropped; halt_seen is unaffected.
//  stall=1 (no flush): in_ready=0; state held; out_valid/out_data stay visible, no pop.
//  halt_seen:
//   - Set on a pop whose halt bit =1; cleared only by reset.
//   - While set, in_ready=0 (stage drains, accepts nothing).
//  SKID=0 (single entry, states EMPTY/FULL):
//   - in_ready = !stall & !flush & !halt_seen & (!out_valid | out_ready).
//   - EMPTY -push-> FULL.
//   - FULL: pop & !push -> EMPTY; pop & push -> FULL with new data.
//  SKID=1 (main reg = head, skid reg; states EMPTY/ONE/TWO):
//   - in_ready = !stall & !flush & !halt_seen & (occupancy!=2).
//   - The occupancy!=2 term is registered, so in_ready has no out_ready path.
//   - EMPTY -push-> ONE (main).
//   - ONE: push&!pop -> TWO (into skid); push&pop -> ONE (main<=in); pop only -> EMPTY.
//   - TWO: pop -> ONE (main<=skid). Push is impossible (in_ready=0).
//   - Order is strict FIFO; no beat lost or duplicated except by flush.
//  Boundary cases:
//   - Simultaneous push+pop at occupancy 1 keeps occupancy 1, full throughput.
//   - out_ready may toggle every cycle.
//   - out_data is stable while out_valid & !out_ready.
//   - flush with stall: flush wins.
//   - Reset mid-transfer discards all state.
// TESTING
//  1 Reset: nRST low mid-stream, occupancy=2 -> next sample occ=0, out_valid=0, out_data=FLUSH_VAL.
//  2 Streaming, SKID=1: beats 0x1..0x10, out_ready=1 -> 16 outputs in order, 1 per cycle from cycle 1.
//  3 Backpressure, SKID=1: out_ready=0 for 3 cycles, in_valid=1 ->
//     occupancy goes 1,2,2; in_ready=0 at occ 2; pushes A,B; release -> A then B, no loss.
//  4 Flush at occ=2 with in_valid=1 (beat C) ->
//     next cycle occ=0, out_valid=0, C never appears, in_ready=0 during flush cycle.
//  5 Stall with out_ready=1, occ=1 for 2 cycles -> out_data held, occupancy 1, no pop, in_ready=0.
//  6 HALT: beat D with in_halt=1 popped ->
//     halt_seen=1 next cycle, in_ready stays 0 until reset; out_halt=1 only while D at head.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with valid/ready handshake, stall, flush and sticky halt.
// SKID=1 adds a second entry so in_ready does not depend on out_ready.
module pipe_stage_elastic #(
    parameter int unsigned        DATA_W    = 128,
    parameter int unsigned        SKID      = 1,
    parameter logic [DATA_W-1:0]  FLUSH_VAL = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic              halt_seen
);

    logic [DATA_W-1:0] r_main_data, r_skid_data;
    logic              r_main_halt, r_skid_halt;
    logic [1:0]        r_occ;
    logic              r_out_valid, r_out_halt, r_halt_seen, r_not_full;

    logic [DATA_W-1:0] w_main_data_nxt, w_skid_data_nxt;
    logic              w_main_halt_nxt, w_skid_halt_nxt;
    logic [1:0]        w_occ_nxt;
    logic              w_halt_seen_nxt;
    logic              w_room, w_push, w_pop;

    // SKID=1 uses the registered not-full flag; SKID=0 lets a pop free the slot same-cycle
    assign w_room   = (SKID != 0) ? r_not_full : (!r_out_valid || out_ready);
    assign in_ready = !stall && !flush && !r_halt_seen && w_room;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = r_out_valid && out_ready && !stall && !flush;

    always_comb begin
        w_main_data_nxt = r_main_data;
        w_main_halt_nxt = r_main_halt;
        w_skid_data_nxt = r_skid_data;
        w_skid_halt_nxt = r_skid_halt;
        w_occ_nxt       = r_occ;
        w_halt_seen_nxt = r_halt_seen || (w_pop && r_main_halt);
        if (flush) begin
            w_main_data_nxt = FLUSH_VAL;
            w_main_halt_nxt = 1'b0;
            w_skid_data_nxt = FLUSH_VAL;
            w_skid_halt_nxt = 1'b0;
            w_occ_nxt       = 2'd0;
        end else if (!stall) begin
            if (SKID == 0) begin
                if (w_push) begin
                    w_main_data_nxt = in_data;
                    w_main_halt_nxt = in_halt;
                    w_occ_nxt       = 2'd1;
                end else if (w_pop) begin
                    w_occ_nxt       = 2'd0;
                end
            end else begin
                case (r_occ)
                    2'd0: begin
                        if (w_push) begin
                            w_main_data_nxt = in_data;
                            w_main_halt_nxt = in_halt;
                            w_occ_nxt       = 2'd1;
                        end
                    end
                    2'd1: begin
                        if (w_push && w_pop) begin
                            w_main_data_nxt = in_data;
                            w_main_halt_nxt = in_halt;
                        end else if (w_push) begin
                            w_skid_data_nxt = in_data;
                            w_skid_halt_nxt = in_halt;
                            w_occ_nxt       = 2'd2;
                        end else if (w_pop) begin
                            w_occ_nxt       = 2'd0;
                        end
                    end
                    default: begin
                        if (w_pop) begin
                            w_main_data_nxt = r_skid_data;
                            w_main_halt_nxt = r_skid_halt;
                            w_occ_nxt       = 2'd1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_main_data <= FLUSH_VAL;
            r_main_halt <= 1'b0;
            r_skid_data <= FLUSH_VAL;
            r_skid_halt <= 1'b0;
            r_occ       <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_halt  <= 1'b0;
            r_halt_seen <= 1'b0;
            r_not_full  <= 1'b1;
        end else begin
            r_main_data <= w_main_data_nxt;
            r_main_halt <= w_main_halt_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_skid_halt <= w_skid_halt_nxt;
            r_occ       <= w_occ_nxt;
            r_out_valid <= (w_occ_nxt != 2'd0);
            r_out_halt  <= (w_occ_nxt != 2'd0) && w_main_halt_nxt;
            r_halt_seen <= w_halt_seen_nxt;
            r_not_full  <= (w_occ_nxt != 2'd2);
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_main_data;
    assign out_halt  = r_out_halt;
    assign occupancy = r_occ;
    assign halt_seen = r_halt_seen;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic (SKID=1): vector table, hand sequences and a
// randomized run checked against a queue-based reference model.
module tb_pipe_stage_elastic;

    localparam int unsigned DW = 32;
    localparam logic [DW-1:0] FV = 32'hDEAD_BEEF;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          in_valid = 1'b0, in_halt = 1'b0, out_ready = 1'b0;
    logic          stall = 1'b0, flush = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, out_halt, halt_seen;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    pipe_stage_elastic #(.DATA_W(DW), .SKID(1), .FLUSH_VAL(FV)) dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_halt(in_halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_halt(out_halt),
        .stall(stall), .flush(flush), .occupancy(occupancy), .halt_seen(halt_seen)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic halt; logic [DW-1:0] data; } beat_t;
    beat_t m_q[$];
    logic  m_hs = 1'b0;
    int    m_pops = 0;
    int    n_checks = 0, n_errors = 0;

    typedef struct {
        logic iv; logic [DW-1:0] d; logic ordy; logic st; logic fl;
        logic [1:0] e_occ; logic e_valid; logic e_chk_data; logic [DW-1:0] e_data; logic e_rdy;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic m_rdy();
        return !stall && !flush && !m_hs && (m_q.size() < 2);
    endfunction

    // Registered outputs against the model, sampled at the falling edge
    task automatic pre_check();
        chk("occupancy", 64'(occupancy), 64'(m_q.size()));
        chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        chk("out_halt", 64'(out_halt), 64'((m_q.size() != 0) && m_q[0].halt));
        chk("halt_seen", 64'(halt_seen), 64'(m_hs));
        if (m_q.size() != 0) chk("out_data", 64'(out_data), 64'(m_q[0].data));
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic h,
                         input logic ordy, input logic st, input logic fl);
        in_valid = iv; in_data = d; in_halt = h; out_ready = ordy; stall = st; flush = fl;
    endtask

    // Check in_ready, then advance the model by one clock edge
    task automatic post();
        logic rdy, push, pop;
        #1;
        rdy  = m_rdy();
        chk("in_ready", 64'(in_ready), 64'(rdy));
        push = in_valid && rdy;
        pop  = (m_q.size() != 0) && out_ready && !stall && !flush;
        if (flush) begin
            m_q.delete();
        end else if (!stall) begin
            if (pop) begin
                m_hs = m_hs | m_q[0].halt;
                void'(m_q.pop_front());
                m_pops++;
            end
            if (push) m_q.push_back({in_halt, in_data});
        end
    endtask

    task automatic step(input logic iv, input logic [DW-1:0] d, input logic h,
                        input logic ordy, input logic st, input logic fl);
        @(negedge CLK);
        pre_check();
        drive(iv, d, h, ordy, st, fl);
        post();
    endtask

    task automatic async_reset_check();
        @(negedge CLK);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 nRST = 1'b0;
        #1;
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'(FV));
        chk("rst_out_halt", 64'(out_halt), 64'd0);
        chk("rst_halt_seen", 64'(halt_seen), 64'd0);
        m_q.delete();
        m_hs = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        #1 chk("rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    vec_t vt[12];

    initial begin
        int pops0;
        //            iv  data          ordy st  fl   occ valid chkd  data         rdy
        vt[0]  = '{1'b1, 32'h0000_000A, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0,         1'b1};
        vt[1]  = '{1'b1, 32'h0000_000B, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'h0000_000A, 1'b1};
        vt[2]  = '{1'b1, 32'h0000_00C2, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 32'h0000_000A, 1'b0};
        vt[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 32'h0000_000A, 1'b0};
        vt[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'h0000_000B, 1'b1};
        vt[5]  = '{1'b1, 32'h0000_000E, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0,         1'b1};
        vt[6]  = '{1'b1, 32'h0000_000F, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h0000_000E, 1'b0};
        vt[7]  = '{1'b1, 32'h0000_000F, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h0000_000E, 1'b0};
        vt[8]  = '{1'b1, 32'h0000_000F, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'h0000_000E, 1'b1};
        vt[9]  = '{1'b1, 32'h0000_0016, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'h0000_000F, 1'b1};
        vt[10] = '{1'b1, 32'h0000_000C, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 32'h0000_000F, 1'b0};
        vt[11] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, FV,            1'b1};

        // Reset state
        #12;
        chk("reset_occ", 64'(occupancy), 64'd0);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_data", 64'(out_data), 64'(FV));
        chk("reset_halt_seen", 64'(halt_seen), 64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        #1 chk("reset_in_ready", 64'(in_ready), 64'd1);

        // Backpressure, stall, flush-with-stall vectors
        foreach (vt[i]) begin
            @(negedge CLK);
            pre_check();
            chk($sformatf("vec%0d_occ", i), 64'(occupancy), 64'(vt[i].e_occ));
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vt[i].e_valid));
            if (vt[i].e_chk_data)
                chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(vt[i].e_data));
            drive(vt[i].iv, vt[i].d, 1'b0, vt[i].ordy, vt[i].st, vt[i].fl);
            post();
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vt[i].e_rdy));
        end

        // Streaming 0x1..0x10 with out_ready held high
        pops0 = m_pops;
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, DW'(k), 1'b0, 1'b1, 1'b0, 1'b0);
            if (k > 1) chk("stream_head", 64'(out_data), 64'(k - 1));
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("stream_last", 64'(out_data), 64'd16);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("stream_pops", 64'(m_pops - pops0), 64'd16);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            step(1'(($urandom % 4) != 0), DW'($urandom), 1'b0, 1'($urandom % 2),
                 1'(($urandom % 8) == 0), 1'(($urandom % 32) == 0));
        end

        // Asynchronous reset while holding two beats
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_occ", 64'(occupancy), 64'd2);
        async_reset_check();

        // HALT beat: sticky halt_seen, stage stops accepting
        step(1'b1, 32'h0000_00D0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("halt_at_head", 64'(out_halt), 64'd1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, DW'(k), 1'b0, 1'b1, 1'b0, 1'b0);
            chk("halt_seen_sticky", 64'(halt_seen), 64'd1);
            chk("halt_blocks_ready", 64'(in_ready), 64'd0);
            chk("halt_out_halt_low", 64'(out_halt), 64'd0);
        end
        async_reset_check();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
